// File: rtl/lfsr_period_monitor_pkg.sv
// Shared definitions for the LFSR period monitor: FSM encodings, tap positions
// and the maximal-period helper.
package lfsr_period_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAIL  = 2'd3
  } mon_state_t;

  localparam int TAP_A = 0;
  localparam int TAP_B = 1;

  // Length of a maximal sequence for a given state width (all-zero excluded).
  function automatic int max_period(input int width);
    return (32'sd1 << width) - 32'sd1;
  endfunction

endpackage

// File: rtl/lfsr_next_state.sv
// Combinational golden step of the x^4+x^3+1 LFSR: state in, expected next state out.
module lfsr_next_state
  import lfsr_period_monitor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_state
);

  assign next_state = {state[TAP_A] ^ state[TAP_B], state[WIDTH-1:1]};

endmodule

// File: rtl/lfsr_period_monitor.sv
// Measures the recurrence period of the LFSR state stream and flags lock-up/timeout.
// Optional recurrence checker enabled by defining LFSR_MON_SEQCHK_EN.
module lfsr_period_monitor
  import lfsr_period_monitor_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 5,
  parameter int TIMEOUT = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             load_in,
  input  logic [WIDTH-1:0] state_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic             max_len,
  output logic             lockup,
  output logic             timeout,
  output logic             seq_err
);

  mon_state_t       state_r, state_nx_s;
  logic [WIDTH-1:0] ref_r, ref_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s, cnt_inc_s;
  logic [CNT_W-1:0] period_r, period_nx_s;
  logic             max_len_r, max_len_nx_s;
  logic             lockup_r, lockup_nx_s;
  logic             timeout_r, timeout_nx_s;
  logic             seq_err_r, seq_err_nx_s;
  logic             busy_r, done_r;

`ifdef LFSR_MON_SEQCHK_EN
  logic [WIDTH-1:0] prev_r, prev_nx_s, expect_s;

  lfsr_next_state #(.WIDTH(WIDTH)) u_next (
    .state      (prev_r),
    .next_state (expect_s)
  );
`endif

  assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state and next-status computation for the measurement FSM.
  always_comb begin
    state_nx_s   = state_r;
    ref_nx_s     = ref_r;
    cnt_nx_s     = cnt_r;
    period_nx_s  = period_r;
    max_len_nx_s = max_len_r;
    lockup_nx_s  = lockup_r;
    timeout_nx_s = timeout_r;
    seq_err_nx_s = seq_err_r;
`ifdef LFSR_MON_SEQCHK_EN
    prev_nx_s    = prev_r;
`endif
    case (state_r)
      ST_IDLE, ST_FAIL: begin
        if (start && !load_in) begin
          ref_nx_s     = state_in;
          cnt_nx_s     = {CNT_W{1'b0}};
          period_nx_s  = {CNT_W{1'b0}};
          max_len_nx_s = 1'b0;
          lockup_nx_s  = 1'b0;
          timeout_nx_s = 1'b0;
          seq_err_nx_s = 1'b0;
`ifdef LFSR_MON_SEQCHK_EN
          prev_nx_s    = state_in;
`endif
          if (state_in == {WIDTH{1'b0}}) begin
            lockup_nx_s = 1'b1;
            state_nx_s  = ST_FAIL;
          end else begin
            state_nx_s  = ST_COUNT;
          end
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_COUNT: begin
`ifdef LFSR_MON_SEQCHK_EN
        prev_nx_s = state_in;
`endif
        // Abort beats checker, checker beats match, match beats timeout.
        if (load_in) begin
          state_nx_s = ST_IDLE;
`ifdef LFSR_MON_SEQCHK_EN
        end else if (state_in != expect_s) begin
          seq_err_nx_s = 1'b1;
          state_nx_s   = ST_FAIL;
`endif
        end else if (state_in == ref_r) begin
          period_nx_s  = cnt_inc_s;
          max_len_nx_s = (cnt_inc_s == CNT_W'(max_period(WIDTH)));
          state_nx_s   = ST_DONE;
        end else if (cnt_inc_s == CNT_W'(TIMEOUT)) begin
          timeout_nx_s = 1'b1;
          state_nx_s   = ST_FAIL;
        end else begin
          cnt_nx_s = cnt_inc_s;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, status and registered output strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      ref_r     <= {WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      period_r  <= {CNT_W{1'b0}};
      max_len_r <= 1'b0;
      lockup_r  <= 1'b0;
      timeout_r <= 1'b0;
      seq_err_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      ref_r     <= ref_nx_s;
      cnt_r     <= cnt_nx_s;
      period_r  <= period_nx_s;
      max_len_r <= max_len_nx_s;
      lockup_r  <= lockup_nx_s;
      timeout_r <= timeout_nx_s;
      seq_err_r <= seq_err_nx_s;
      busy_r    <= (state_nx_s == ST_COUNT);
      done_r    <= (state_nx_s == ST_DONE);
    end
  end

`ifdef LFSR_MON_SEQCHK_EN
  // Previous LFSR sample for the recurrence checker.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_r <= {WIDTH{1'b0}};
    end else begin
      prev_r <= prev_nx_s;
    end
  end

  assign seq_err = seq_err_r;
`else
  assign seq_err = 1'b0;
`endif

  assign busy    = busy_r;
  assign done    = done_r;
  assign period  = period_r;
  assign max_len = max_len_r;
  assign lockup  = lockup_r;
  assign timeout = timeout_r;

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Self-checking bench: two monitors (TIMEOUT 31 and 8) against an elapsed-cycle reference model.
module tb_lfsr_period_monitor;

  localparam int W  = 4;
  localparam int CW = 5;

  logic         clk = 1'b0;
  logic         reset, start, load_in;
  logic [W-1:0] state_in;

  logic          busy_w[2], done_w[2], max_w[2], lock_w[2], to_w[2], seq_w[2];
  logic [CW-1:0] period_w[2];

  int lim[2] = '{31, 8};
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode 0 idle, 1 measuring, 2 done, 3 failed.
  int m_mode[2], m_ref[2], m_el[2], m_prev[2];
  int e_period[2], e_max[2], e_lock[2], e_to[2], e_seq[2], e_done[2];

  always #5 clk = ~clk;

  lfsr_period_monitor #(.WIDTH(W), .CNT_W(CW), .TIMEOUT(31)) dut (
    .clk(clk), .reset(reset), .start(start), .load_in(load_in), .state_in(state_in),
    .busy(busy_w[0]), .done(done_w[0]), .period(period_w[0]), .max_len(max_w[0]),
    .lockup(lock_w[0]), .timeout(to_w[0]), .seq_err(seq_w[0])
  );

  lfsr_period_monitor #(.WIDTH(W), .CNT_W(CW), .TIMEOUT(8)) dut_t (
    .clk(clk), .reset(reset), .start(start), .load_in(load_in), .state_in(state_in),
    .busy(busy_w[1]), .done(done_w[1]), .period(period_w[1]), .max_len(max_w[1]),
    .lockup(lock_w[1]), .timeout(to_w[1]), .seq_err(seq_w[1])
  );

  function automatic int lfsr_step(input int s);
    return (s >> 1) | (((s ^ (s >> 1)) & 1) << 3);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_ref[i] = 0; m_el[i] = 0; m_prev[i] = 0;
      e_period[i] = 0; e_max[i] = 0; e_lock[i] = 0; e_to[i] = 0; e_seq[i] = 0; e_done[i] = 0;
    end
  endtask

  task automatic model_step();
    int s;
    bit chk_en;
    s = int'(state_in);
`ifdef LFSR_MON_SEQCHK_EN
    chk_en = 1'b1;
`else
    chk_en = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      e_done[i] = 0;
      if (m_mode[i] == 0 || m_mode[i] == 3) begin
        if (start && !load_in) begin
          m_ref[i] = s; m_el[i] = 0; m_prev[i] = s;
          e_period[i] = 0; e_max[i] = 0; e_lock[i] = 0; e_to[i] = 0; e_seq[i] = 0;
          if (s == 0) begin e_lock[i] = 1; m_mode[i] = 3; end
          else m_mode[i] = 1;
        end
      end else if (m_mode[i] == 1) begin
        m_el[i]++;
        if (load_in) m_mode[i] = 0;
        else if (chk_en && s != lfsr_step(m_prev[i])) begin e_seq[i] = 1; m_mode[i] = 3; end
        else if (s == m_ref[i]) begin
          e_period[i] = m_el[i]; e_max[i] = (m_el[i] == 15); e_done[i] = 1; m_mode[i] = 2;
        end else if (m_el[i] == lim[i]) begin e_to[i] = 1; m_mode[i] = 3; end
        m_prev[i] = s;
      end else begin
        m_mode[i] = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("busy[%0d]", i),    32'(busy_w[i]),   32'(m_mode[i] == 1));
      check_val($sformatf("done[%0d]", i),    32'(done_w[i]),   32'(e_done[i]));
      check_val($sformatf("period[%0d]", i),  32'(period_w[i]), 32'(e_period[i]));
      check_val($sformatf("max_len[%0d]", i), 32'(max_w[i]),    32'(e_max[i]));
      check_val($sformatf("lockup[%0d]", i),  32'(lock_w[i]),   32'(e_lock[i]));
      check_val($sformatf("timeout[%0d]", i), 32'(to_w[i]),     32'(e_to[i]));
      check_val($sformatf("seq_err[%0d]", i), 32'(seq_w[i]),    32'(e_seq[i]));
    end
  endtask

  task automatic cyc(input logic st, input logic ld, input int s);
    start    = st;
    load_in  = ld;
    state_in = W'(s);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  initial begin
    int s;
    int r;
    reset = 1'b0; start = 1'b0; load_in = 1'b0; state_in = '0;
    model_reset();
    #1;
    compare_outputs();
    @(negedge clk);
    reset = 1'b1;

    // Maximal sequence from seed 1000; the TIMEOUT=8 instance times out.
    cyc(1'b0, 1'b1, 8);
    s = 8;
    cyc(1'b1, 1'b0, s);
    for (int k = 0; k < 20; k++) begin s = lfsr_step(s); cyc(1'b0, 1'b0, s); end
    check_val("dir_period15", 32'(period_w[0]), 32'd15);
    check_val("dir_timeout8", 32'(to_w[1]), 32'd1);

    // All-zero capture locks up.
    cyc(1'b1, 1'b0, 0);
    cyc(1'b0, 1'b0, 0);
    check_val("dir_lockup", 32'(lock_w[0]), 32'd1);

    // Seed 1001, abort by seed load after five counting cycles.
    s = 9;
    cyc(1'b1, 1'b0, s);
    for (int k = 0; k < 5; k++) begin s = lfsr_step(s); cyc(1'b0, 1'b0, s); end
    cyc(1'b0, 1'b1, 3);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 3);

    // Stuck LFSR gives period 1.
    cyc(1'b1, 1'b0, 6);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 6);
    check_val("dir_period1", 32'(period_w[0]), 32'd1);

    // Broken recurrence 1000 -> 0101.
    cyc(1'b1, 1'b0, 8);
    cyc(1'b0, 1'b0, 5);
    cyc(1'b0, 1'b0, lfsr_step(5));
    cyc(1'b0, 1'b0, lfsr_step(lfsr_step(5)));

    // Asynchronous reset in the middle of a measurement.
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1);
    s = 12;
    cyc(1'b1, 1'b0, s);
    for (int k = 0; k < 3; k++) begin s = lfsr_step(s); cyc(1'b0, 1'b0, s); end
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
    reset = 1'b1;

    // Randomized LFSR-like stream with loads, glitches and starts.
    s = int'($urandom_range(0, 15));
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 63));
      if (r < 4) begin
        s = int'($urandom_range(0, 15));
        cyc(($urandom_range(0, 3) == 0), 1'b1, s);
      end else begin
        if (r < 6) s = int'($urandom_range(0, 15));
        else s = lfsr_step(s);
        cyc(($urandom_range(0, 7) == 0), 1'b0, s);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_period_monitor.md
Name: lfsr_period_monitor

Overview:
- Downstream consumer of the 4-bit LFSR state stream (recurrence x^4+x^3+1: next = {s[0]^s[1], s[3:1]}).
- On request, captures the current LFSR state and counts clocks until that state recurs.
- Reports the measured period, whether it is maximal length (2^WIDTH-1), and lock-up or timeout failures.
- Used as a self-check stage beside the LFSR in both simulation and synthesis.

Parameters:
- WIDTH, 4, LFSR state width.
- CNT_W, 5, width of the cycle counter and of period.
- TIMEOUT, 31, maximum cycles counted before a timeout failure (must be ≤ 2^CNT_W-1).

Ports:
- clk  in  1  rising-edge clock, shared with the LFSR.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  measurement request; sampled only in IDLE or FAIL.
- load_in  in  1  copy of the LFSR seed-load select; 1 = LFSR is loading a seed.
- state_in  in  WIDTH  LFSR state output.
- busy  out  1  high while in COUNT.
- done  out  1  one-cycle pulse when a period is measured.
- period  out  CNT_W  last measured period; held until the next accepted start.
- max_len  out  1  period == 2^WIDTH-1; held with period.
- lockup  out  1  captured state was all-zero; sticky until the next accepted start.
- timeout  out  1  no recurrence within TIMEOUT cycles; sticky until the next accepted start.
- seq_err  out  1  recurrence violation (see Optional Feature); sticky until the next accepted start.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; ref, cnt, period=0; busy, done, max_len, lockup, timeout, seq_err=0.
- FSM states: IDLE, COUNT, DONE, FAIL.
- IDLE/FAIL, start=1 and load_in=0:
  - ref<=state_in, cnt<=0, and all status outputs are cleared.
  - If state_in==0: lockup<=1, go to FAIL.
  - Otherwise go to COUNT.
- start=1 together with load_in=1: start is ignored and the FSM stays in its current state.
- COUNT, each edge:
  - load_in=1: abort to IDLE. period and flags stay cleared; no done.
  - Else if state_in==ref: period<=cnt+1, max_len<=(cnt+1==2^WIDTH-1), go to DONE.
  - Else if cnt+1==TIMEOUT: timeout<=1, go to FAIL.
  - Else cnt<=cnt+1.
- Match takes priority over timeout on the same edge.
- Latency: a state captured at edge T0 that recurs at edge Tk gives period=k. done is asserted in the cycle after edge Tk.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. A start during DONE is ignored.
- FAIL: holds until an accepted start, which re-arms directly to COUNT (or back to FAIL on a zero state).
- busy=1 iff state==COUNT.
- cnt never wraps, because TIMEOUT bounds it.

Optional Feature:
- Macro: LFSR_MON_SEQCHK_EN.
- With the macro: in COUNT, the previous state_in is registered. If state_in != {prev[0]^prev[1], prev[WIDTH-1:1]}, then seq_err<=1 and the FSM goes to FAIL.
  - Priority on the same edge: load_in abort first, then seq_err, then match, then timeout.
  - The check is valid for WIDTH=4 taps only.
- Without the macro: seq_err is tied to 0 and no prev register exists.

Decomposition:
- Shared include LfsrDefs.v holds:
  - FSM state encodings (IDLE=2'd0, COUNT=2'd1, DONE=2'd2, FAIL=2'd3);
  - tap positions (TAP_A=0, TAP_B=1);
  - the maximal-period constant 2^WIDTH-1.
- One natural sub-module: lfsr_next_state. It is combinational: WIDTH-bit state in, expected next state out. It is used by the checker and reusable by the LFSR testbench as a golden model.

Test Plan:
- LFSR seeded 4'b1000, then start → busy for 15 cycles, done pulse, period=15, max_len=1, no flags.
- Seed 4'b0000, start → FAIL next cycle with lockup=1, busy=0, no done.
- Start with seed 4'b1001, then load_in=1 at cycle 5 of COUNT → IDLE; done never pulses; period=0.
- state_in held constant at 4'b0110 (stuck LFSR), start → period=1, max_len=0, done pulse.
- TIMEOUT=8, driven non-repeating sequence → timeout=1 at cycle 8, FAIL; a new start clears timeout.
- With LFSR_MON_SEQCHK_EN: inject 4'b1000 → 4'b0101 → seq_err=1, FAIL. Without the macro, the same stimulus keeps seq_err=0.
- reset pulsed low mid-COUNT → all outputs 0 immediately, without waiting for a clock edge.
